// File: rtl/wb_splitter_pkg.sv
// Shared types and constants for the Wishbone slave splitter.
package wb_splitter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  // A single peripheral still needs one index bit so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Window decoder: splits the upper address bits into region tag and peripheral index.
module wb_addr_decode
  import wb_splitter_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          SPAN_LOG2  = 20,
  parameter int          IDX_W      = 2
) (
  input  logic [ADDR_W-1-SPAN_LOG2:0] adr,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx,
  output logic                        mapped
);

  localparam int TAG_LSB = SPAN_LOG2 + IDX_W;
  localparam logic [ADDR_W-1-TAG_LSB:0] BASE_TAG = ADDR_BASE[ADDR_W-1:TAG_LSB];
  // One extra bit so NUM_SLAVES itself is representable when it is a power of two.
  localparam logic [IDX_W:0] SLAVE_LIMIT = NUM_SLAVES[IDX_W:0];

  assign hit    = (adr[ADDR_W-1-SPAN_LOG2:IDX_W] == BASE_TAG);
  assign idx    = adr[IDX_W-1:0];
  assign mapped = hit && ({1'b0, idx} < SLAVE_LIMIT);

endmodule

// File: rtl/wb_slave_splitter.sv
// N-way Wishbone slave splitter with per-peripheral windows, ack timeout and error reporting.
module wb_slave_splitter
  import wb_splitter_pkg::*;
#(
  parameter int                NUM_SLAVES     = 4,
  parameter logic [31:0]       ADDR_BASE      = 32'h3000_0000,
  parameter int                SPAN_LOG2      = 20,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_ni,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SEL_W-1:0]             wbs_sel_i,
  input  logic [ADDR_W-1:0]            wbs_adr_i,
  input  logic [DATA_W-1:0]            wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic [DATA_W-1:0]            wbs_dat_o,
  output logic [NUM_SLAVES-1:0]        m_cyc_o,
  output logic [NUM_SLAVES-1:0]        m_stb_o,
  output logic                         m_we_o,
  output logic [SEL_W-1:0]             m_sel_o,
  output logic [ADDR_W-1:0]            m_adr_o,
  output logic [DATA_W-1:0]            m_dat_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_dat_i,
  input  logic [NUM_SLAVES-1:0]        m_ack_i,
  output logic                         err_irq_o,
  output logic [15:0]                  err_cnt_o
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int TMR_LAST_I = TIMEOUT_CYCLES - 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_LAST_I[TMR_W-1:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                  dec_hit;
  logic                  dec_mapped;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] onehot;

  state_e                state_q;
  state_e                state_d;
  logic [IDX_W-1:0]      idx_q;
  logic [TMR_W-1:0]      timer_q;

  logic                  accept;
  logic                  launch;
  logic                  drop;
  logic                  resp_ok;
  logic                  resp_err;
  logic                  slave_ack;
  logic [DATA_W-1:0]     slave_dat;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASE  (ADDR_BASE),
    .SPAN_LOG2  (SPAN_LOG2),
    .IDX_W      (IDX_W)
  ) u_decode (
    .adr    (wbs_adr_i[ADDR_W-1:SPAN_LOG2]),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .mapped (dec_mapped)
  );

  assign onehot    = NUM_SLAVES'(1) << dec_idx;
  assign slave_ack = m_ack_i[idx_q];
  assign slave_dat = m_dat_i[{idx_q, 5'd0} +: DATA_W];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort beats ack, and ack beats timeout, when they coincide in REQ.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    launch   = 1'b0;
    drop     = 1'b0;
    resp_ok  = 1'b0;
    resp_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          accept = 1'b1;
          if (dec_hit && dec_mapped) begin
            launch  = 1'b1;
            state_d = REQ;
          end else begin
            resp_err = 1'b1;
            state_d  = RESP;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (slave_ack) begin
          drop    = 1'b1;
          resp_ok = 1'b1;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          drop     = 1'b1;
          resp_err = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture / downstream strobe / response registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel_o   <= '0;
      m_we_o    <= 1'b0;
      idx_q     <= '0;
      m_cyc_o   <= '0;
      m_stb_o   <= '0;
      timer_q   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      err_irq_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      if (accept) begin
        m_adr_o <= wbs_adr_i;
        m_dat_o <= wbs_dat_i;
        m_sel_o <= wbs_sel_i;
        m_we_o  <= wbs_we_i;
        idx_q   <= dec_idx;
      end

      if (launch) begin
        m_cyc_o <= onehot;
        m_stb_o <= onehot;
      end else if (drop) begin
        m_cyc_o <= '0;
        m_stb_o <= '0;
      end

      if (launch) begin
        timer_q <= '0;
      end else if (state_q == REQ && !slave_ack) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      wbs_ack_o <= resp_ok | resp_err;
      err_irq_o <= resp_err;

      if (resp_ok) begin
        wbs_dat_o <= slave_dat;
      end else if (resp_err) begin
        wbs_dat_o <= ERR_DATA;
      end

      if (resp_err) begin
        err_cnt_o <= sat_inc(err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_splitter.sv
// Scoreboard bench for wb_slave_splitter with behavioural peripherals of programmable ack delay.
module tb_wb_slave_splitter;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cyc, stb, we;
  logic [3:0]     sel;
  logic [31:0]    adr, wdat;
  logic           ack;
  logic [31:0]    rdat;
  logic [NS-1:0]  m_cyc, m_stb;
  logic           m_we;
  logic [3:0]     m_sel;
  logic [31:0]    m_adr, m_dat;
  logic [NS*32-1:0] m_dat_in;
  logic [NS-1:0]  m_ack_in;
  logic           irq;
  logic [15:0]    cnt;

  always #5 clk = ~clk;

  wb_slave_splitter #(
    .NUM_SLAVES     (NS),
    .ADDR_BASE      (32'h3000_0000),
    .SPAN_LOG2      (20),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERR)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .m_cyc_o   (m_cyc),
    .m_stb_o   (m_stb),
    .m_we_o    (m_we),
    .m_sel_o   (m_sel),
    .m_adr_o   (m_adr),
    .m_dat_o   (m_dat),
    .m_dat_i   (m_dat_in),
    .m_ack_i   (m_ack_in),
    .err_irq_o (irq),
    .err_cnt_o (cnt)
  );

  // Peripheral model: ack when the strobe has been high for dly[k] previous cycles.
  int unsigned dly  [NS];
  logic [31:0] sdat [NS];
  int unsigned scnt [NS];
  logic [NS-1:0] noise_ack;

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) scnt[k] <= m_stb[k] ? scnt[k] + 1 : 0;
  end

  always_comb begin
    m_ack_in = noise_ack;
    m_dat_in = '0;
    for (int k = 0; k < NS; k++) begin
      if (m_stb[k] && scnt[k] == dly[k]) m_ack_in[k] = 1'b1;
      m_dat_in[k*32 +: 32] = sdat[k];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          acks_seen = 0;
  int          stb_cyc [NS];
  logic [31:0] exp_adr, exp_wdat;
  logic [3:0]  exp_sel;
  logic        exp_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"},   32'(ack),   32'h0);
    chk({tag, "_rdat"},  rdat,       32'h0);
    chk({tag, "_mcyc"},  32'(m_cyc), 32'h0);
    chk({tag, "_mstb"},  32'(m_stb), 32'h0);
    chk({tag, "_madr"},  m_adr,      32'h0);
    chk({tag, "_mdat"},  m_dat,      32'h0);
    chk({tag, "_msel"},  32'(m_sel), 32'h0);
    chk({tag, "_mwe"},   32'(m_we),  32'h0);
    chk({tag, "_irq"},   32'(irq),   32'h0);
    chk({tag, "_cnt"},   32'(cnt),   32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        acks_seen++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rdata", rdat, e.data);
          chk("irq_with_ack", 32'(irq), 32'(e.err));
        end
      end else if (irq) begin
        chk("irq_without_ack", 32'(irq), 32'h0);
      end
      if (m_stb != '0) begin
        chk("cyc_eq_stb", 32'(m_cyc), 32'(m_stb));
        chk("stb_onehot", $countones(m_stb), 32'd1);
        chk("m_adr_hold", m_adr, exp_adr);
        chk("m_dat_hold", m_dat, exp_wdat);
        chk("m_sel_hold", 32'(m_sel), 32'(exp_sel));
        chk("m_we_hold",  32'(m_we), 32'(exp_we));
        for (int k = 0; k < NS; k++) stb_cyc[k] += int'(m_stb[k]);
      end
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
    exp_adr = a; exp_wdat = d; exp_sel = s; exp_we = w;
    adr = a; wdat = d; sel = s; we = w;
    cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic access(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    drive_req(a, w, d, s);
    sb_q.push_back('{data: exp_data, err: exp_err});
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0;
    stb = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, c0;
    int s[NS];
    bit got;

    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; wdat = '0;
    noise_ack = '0;
    exp_adr = '0; exp_wdat = '0; exp_sel = '0; exp_we = 1'b0;
    for (int k = 0; k < NS; k++) begin
      dly[k] = 1000; sdat[k] = 32'h1111_0000 + k; stb_cyc[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    // Read slave 2, first-cycle ack
    sdat[2] = 32'h1234_5678; dly[2] = 0;
    s = stb_cyc;
    access("rd_s2", 32'h3020_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2);
    chk("rd_s2_stb_cycles", stb_cyc[2] - s[2], 1);
    chk("rd_s2_other_stb", (stb_cyc[0]-s[0]) + (stb_cyc[1]-s[1]) + (stb_cyc[3]-s[3]), 0);
    chk("rd_s2_errcnt", 32'(cnt), 32'd0);

    // Write slave 0, ack in the 5th strobe cycle
    sdat[0] = 32'h0BAD_F00D; dly[0] = 4;
    s = stb_cyc; a0 = acks_seen;
    access("wr_s0", 32'h3000_0004, 1'b1, 32'hA5A5_0001, 4'b0011, 32'h0BAD_F00D, 1'b0, 6);
    repeat (2) @(negedge clk);
    chk("wr_s0_stb_cycles", stb_cyc[0] - s[0], 5);
    chk("wr_s0_one_ack", acks_seen - a0, 1);

    // Unmapped accesses and the top mapped window edge
    s = stb_cyc;
    access("unmapped_lo", 32'h4000_0000, 1'b0, 32'h0, 4'hF, ERR, 1'b1, 1);
    chk("unmapped_no_stb", stb_cyc[0]+stb_cyc[1]+stb_cyc[2]+stb_cyc[3] - (s[0]+s[1]+s[2]+s[3]), 0);
    chk("unmapped_errcnt1", 32'(cnt), 32'd1);
    access("unmapped_hi", 32'h3040_0000, 1'b0, 32'h0, 4'hF, ERR, 1'b1, 1);
    chk("unmapped_errcnt2", 32'(cnt), 32'd2);
    sdat[3] = 32'hCAFE_F00D; dly[3] = 0;
    access("rd_s3_edge", 32'h303F_FFFC, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 2);

    // Timeout on slave 1 with stray acks from the other slaves
    dly[1] = 1000; noise_ack = 4'b1101;
    s = stb_cyc;
    access("tmo", 32'h3010_0000, 1'b0, 32'h0, 4'hF, ERR, 1'b1, TMO + 1);
    noise_ack = '0;
    chk("tmo_stb_cycles", stb_cyc[1] - s[1], TMO);
    chk("tmo_errcnt", 32'(cnt), 32'd3);

    // Ack coinciding with the last timer cycle wins
    dly[1] = TMO - 1; sdat[1] = 32'h600D_DA7A;
    s = stb_cyc;
    access("ack_at_tmo", 32'h3010_0020, 1'b0, 32'h0, 4'hF, 32'h600D_DA7A, 1'b0, TMO + 1);
    chk("ack_at_tmo_stb_cycles", stb_cyc[1] - s[1], TMO);
    chk("ack_at_tmo_errcnt", 32'(cnt), 32'd3);

    // Abort by dropping cyc in the 3rd REQ cycle
    dly[3] = 1000;
    a0 = acks_seen;
    @(negedge clk);
    drive_req(32'h3030_0000, 1'b0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    chk("abort_in_req", 32'(m_cyc), 32'b1000);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort_cyc_drop", 32'(m_cyc), 32'h0);
    chk("abort_stb_drop", 32'(m_stb), 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_no_ack", acks_seen - a0, 0);
    chk("abort_errcnt", 32'(cnt), 32'd3);
    dly[3] = 1; sdat[3] = 32'h0000_ABCD;
    access("after_abort", 32'h3030_0008, 1'b0, 32'h0, 4'hF, 32'h0000_ABCD, 1'b0, 3);

    // Reset while a request is outstanding
    dly[1] = 1000;
    @(negedge clk);
    drive_req(32'h3010_0004, 1'b1, 32'h7777_8888, 4'b1100);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_mid_cyc", 32'(m_cyc), 32'h0);
    @(negedge clk);
    chk_reset("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);

    // Saturate the error counter with a strobe held on an unmapped address
    drive_req(32'h4000_0000, 1'b0, 32'h0, 4'hF);
    for (int i = 1; i <= 32'h10001; i++) begin
      sb_q.push_back('{data: ERR, err: 1'b1});
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        @(negedge clk);
        if (ack) got = 1'b1;
      end
      if (!got) begin
        chk("sat_ack_wait", 32'h0, 32'h1);
        break;
      end
      if (i == 32'hFFFE) chk("sat_cnt_fffe", 32'(cnt), 32'hFFFE);
      if (i == 32'hFFFF) chk("sat_cnt_ffff", 32'(cnt), 32'hFFFF);
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    c0 = 32'(cnt);
    chk("sat_cnt_hold", c0, 32'hFFFF);
    chk("queue_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_slave_splitter.md
Name: wb_slave_splitter

Overview:
Parametrised Wishbone front-end between the management SoC slave port (wbs_*) and NUM_SLAVES user-area peripherals. It decodes each management access into one address window per peripheral and registers the request downstream. It returns either the peripheral's response or a defined error response, for unmapped addresses and for peripherals that time out. It also provides an error interrupt and a saturating error counter. It replaces the single fixed slave hookup with an N-way, fault-tolerant port.

Parameters:
NUM_SLAVES, 4, number of downstream peripherals (1..16); IDX_W = max(1, clog2(NUM_SLAVES)) is derived.
ADDR_BASE, 32'h3000_0000, base of the decoded region.
SPAN_LOG2, 20, log2 of the window size per peripheral in bytes.
TIMEOUT_CYCLES, 255, maximum number of cycles to wait for a peripheral ack (>=2).
ERR_DATA, 32'hDEAD_BEEF, read data returned on an error response.

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  synchronous active-low reset
wbs_cyc_i  in  1  cycle from management SoC
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
m_cyc_o  out  NUM_SLAVES  one-hot cycle to the peripherals
m_stb_o  out  NUM_SLAVES  one-hot strobe
m_we_o  out  1  registered write enable (shared)
m_sel_o  out  4  registered byte enables (shared)
m_adr_o  out  32  registered address (shared)
m_dat_o  out  32  registered write data (shared)
m_dat_i  in  NUM_SLAVES*32  read data; slave k occupies bits [k*32 +: 32]
m_ack_i  in  NUM_SLAVES  per-slave acknowledge
err_irq_o  out  1  one-cycle pulse on each error response
err_cnt_o  out  16  saturating count of error responses

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: m_cyc_o, m_stb_o, m_adr_o, m_dat_o, m_sel_o, m_we_o, wbs_ack_o, wbs_dat_o, err_irq_o, err_cnt_o.
  - Reset mid-transaction drops the downstream cycle immediately and produces no ack.
- Address decode:
  - Hit when wbs_adr_i[31:SPAN_LOG2+IDX_W] == ADDR_BASE[31:SPAN_LOG2+IDX_W].
  - The slave index is wbs_adr_i[SPAN_LOG2 +: IDX_W].
  - Mapped means hit AND index < NUM_SLAVES.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Waits for wbs_cyc_i & wbs_stb_i.
  - On a request, latches adr, dat, sel, we and the index.
  - Mapped: go to REQ and assert m_cyc_o/m_stb_o bit [idx] from the next cycle.
  - Unmapped: go to RESP with data = ERR_DATA, flagged as an error.
- REQ:
  - Holds the one-hot cyc/stb and shared signals stable.
  - The timer starts at 0 on entry and increments each cycle without m_ack_i[idx].
  - m_ack_i[idx]=1: capture m_dat_i slice idx (writes capture it too; it is ignored by the master), drop cyc/stb at the next edge, go to RESP.
  - Timer == TIMEOUT_CYCLES-1 with no ack: drop cyc/stb, go to RESP with ERR_DATA, flagged as an error.
  - An ack in the same cycle as the timeout wins; it is not an error.
  - Acks on non-selected bits are ignored.
  - wbs_cyc_i falling in REQ is an abort: drop cyc/stb, go to IDLE, no wbs_ack_o, no error.
- RESP:
  - wbs_ack_o=1 for exactly one cycle with wbs_dat_o valid, then back to IDLE.
  - wbs_dat_o holds its value until the next response.
  - Error responses also pulse err_irq_o in the same cycle and increment err_cnt_o, saturating at 16'hFFFF.
- Latency:
  - Unmapped access: ack 1 cycle after the request is sampled.
  - Mapped access where the slave acks in its first strobe cycle: ack 2 cycles after the request is sampled.
  - Timeout: ack TIMEOUT_CYCLES+1 cycles after the request is sampled.
- Back-to-back: a new request is accepted only in IDLE, so at least 1 idle cycle separates acks. A strobe held high after an ack is treated as a new request.
- Only one outstanding transaction exists at a time; there is no pipelining across requests.

Decomposition:
- Shared package wb_splitter_pkg holds:
  - the state enum (IDLE, REQ, RESP);
  - ERR_DATA default;
  - the idx width function.
- One natural sub-module, wb_addr_decode (combinational): takes adr and outputs hit, idx and mapped.
- The FSM, timer and counter live in the top module.

Test Plan:
- Read slave 2 at 0x3020_0010; slave acks in its first cycle with 0x1234_5678 -> only m_stb_o[2] high for 1 cycle; wbs_ack_o 2 cycles after the request with wbs_dat_o=0x1234_5678; err_cnt_o=0.
- Write 0xA5A5_0001 with sel=4'b0011 to slave 0 at 0x3000_0004; slave acks after 5 cycles -> m_dat_o/m_sel_o stable for all 5 cycles; exactly one wbs_ack_o pulse.
- Read at 0x4000_0000 (unmapped) -> no m_stb_o activity; ack 1 cycle later with 0xDEAD_BEEF; err_irq_o pulse; err_cnt_o=1.
- Read slave 1 with TIMEOUT_CYCLES=8 and the slave never acks -> m_stb_o[1] high for 8 cycles; ack with 0xDEAD_BEEF; err_cnt_o increments. A second run with the ack arriving in timer cycle 7 -> real data returned, no error.
- wbs_cyc_i dropped on the 3rd REQ cycle -> m_cyc_o=0 next cycle; no wbs_ack_o; FSM in IDLE; the next request is served normally.
- wb_rst_ni=0 during REQ, then 0x10000 forced errors -> all outputs 0 after reset; err_cnt_o saturates at 16'hFFFF.
